// File: rtl/meas_pkg.sv
// meas_pkg: shared state encoding and averaging constants for the measurement window controller
`timescale 1ns/1ps
package meas_pkg;
    typedef enum logic [1:0] {IDLE, ARM, GATE, DONE} state_t;
    localparam int CNT_W_DEF   = 8;
    localparam int AVG_WINDOWS = 4;
    localparam int AVG_SHIFT   = 2;
endpackage

// File: rtl/meas_edge_sync.sv
// meas_edge_sync: 2-flop synchroniser plus rising-edge detector for an asynchronous input
`timescale 1ns/1ps
module meas_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise
);
    logic s1, s2, s3;
    always_ff @(posedge clk or negedge reset)
        if (!reset) {s3, s2, s1} <= 3'b000;
        else        {s3, s2, s1} <= {s2, s1, din};
    assign rise = s2 & ~s3;
endmodule

// File: rtl/meas_window_ctrl.sv
// meas_window_ctrl: counts synchronised rising edges over a gate window and presents the result under valid/ack.
// Define MEAS_AVG_EN to average the result over AVG_WINDOWS back-to-back windows per start.
`timescale 1ns/1ps
import meas_pkg::*;
module meas_window_ctrl #(
    parameter int GATE_CYCLES = 1000,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             MeasuredSignal,
    input  logic             ack,
    output logic             busy,
    output logic             gate,
    output logic [CNT_W-1:0] count,
    output logic             overflow,
    output logic             valid
);
    localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GW-1:0] G_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SAT = '1;
    state_t state;
    logic [GW-1:0] gcnt;
    logic [CNT_W-1:0] ecnt, ecnt_nxt;
    logic rise, sat_hit, last;
    meas_edge_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .din   (MeasuredSignal),
        .rise  (rise)
    );
    // an edge arriving at saturation is recorded as overflow rather than wrapping
    assign sat_hit  = rise & (ecnt == SAT);
    assign ecnt_nxt = (rise & ~sat_hit) ? ecnt + 1'b1 : ecnt;
    assign last     = gcnt == G_LAST;
`ifdef MEAS_AVG_EN
    localparam int SW = CNT_W + AVG_SHIFT;
    localparam int WW = $clog2(AVG_WINDOWS);
    localparam logic [WW-1:0] W_LAST = WW'(AVG_WINDOWS - 1);
    logic [SW-1:0] sum, sum_nxt;
    logic [WW-1:0] win;
    assign sum_nxt = sum + SW'(ecnt_nxt);
`endif
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            gate     <= 1'b0;
            valid    <= 1'b0;
            overflow <= 1'b0;
            count    <= '0;
            gcnt     <= '0;
            ecnt     <= '0;
`ifdef MEAS_AVG_EN
            sum      <= '0;
            win      <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (start) begin
                    state <= ARM;
                    busy  <= 1'b1;
                end
                ARM: begin
                    ecnt     <= '0;
                    gcnt     <= '0;
                    overflow <= 1'b0;
`ifdef MEAS_AVG_EN
                    sum      <= '0;
                    win      <= '0;
`endif
                    state    <= GATE;
                    gate     <= 1'b1;
                end
                GATE: begin
                    ecnt     <= ecnt_nxt;
                    overflow <= overflow | sat_hit;
                    gcnt     <= last ? '0 : gcnt + 1'b1;
`ifdef MEAS_AVG_EN
                    if (last) begin
                        ecnt <= '0;
                        sum  <= sum_nxt;
                        win  <= win + 1'b1;
                        if (win == W_LAST) begin
                            state <= DONE;
                            gate  <= 1'b0;
                            valid <= 1'b1;
                            count <= sum_nxt[SW-1:AVG_SHIFT];
                        end
                    end
`else
                    if (last) begin
                        state <= DONE;
                        gate  <= 1'b0;
                        valid <= 1'b1;
                        count <= ecnt_nxt;
                    end
`endif
                end
                DONE: if (ack) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_meas_window_ctrl.sv
// tb_meas_window_ctrl: directed self-checking bench for meas_window_ctrl
`timescale 1ns/1ps
module tb_meas_window_ctrl;
    localparam int GA = 100;
    localparam int GB = 1000;
`ifdef MEAS_AVG_EN
    localparam int NW = 4;
`else
    localparam int NW = 1;
`endif
    logic clk = 1'b0, reset = 1'b1, sig = 1'b0;
    logic start_a = 1'b0, ack_a = 1'b0, start_b = 1'b0, ack_b = 1'b0;
    logic busy_a, gate_a, overflow_a, valid_a, busy_b, gate_b, overflow_b, valid_b;
    logic [7:0] count_a, count_b;
    int mode = 0;
    int checks = 0, errors = 0;
    meas_window_ctrl #(.GATE_CYCLES(GA)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .MeasuredSignal(sig), .ack(ack_a),
        .busy(busy_a), .gate(gate_a), .count(count_a), .overflow(overflow_a), .valid(valid_a)
    );
    meas_window_ctrl #(.GATE_CYCLES(GB)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .MeasuredSignal(sig), .ack(ack_b),
        .busy(busy_b), .gate(gate_b), .count(count_b), .overflow(overflow_b), .valid(valid_b)
    );
    always #20 clk = ~clk;
    // mode 1: period 4 clk cycles, mode 2: period 2 clk cycles, else held low
    initial begin : osc
        int ph;
        ph = 0;
        forever begin
            @(negedge clk);
            ph++;
            sig = (mode == 1) ? ph[1] : (mode == 2) ? ph[0] : 1'b0;
        end
    end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask
    task automatic run_a(input int poke, output int ghi, output int lat);
        ghi = 0;
        lat = 0;
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        for (int t = 1; t <= NW * GA + 50; t++) begin
            if (gate_a) ghi++;
            if (valid_a) begin
                lat = t;
                break;
            end
            start_a = (t == poke);
            @(negedge clk);
        end
        start_a = 1'b0;
    endtask
    initial begin
        int ghi, lat, bad;
        #5 reset = 1'b0;
        #100;
        chk("rst_busy", busy_a, 0);
        chk("rst_gate", gate_a, 0);
        chk("rst_count", count_a, 0);
        chk("rst_overflow", overflow_a, 0);
        chk("rst_valid", valid_a, 0);
        @(negedge clk);
        reset = 1'b1;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (busy_a) bad++;
        end
        chk("idle_busy", bad, 0);
        mode = 1;
        repeat (4) @(negedge clk);
        run_a(50, ghi, lat);
        chk("p4_gate_len", ghi, NW * GA);
        chk("p4_latency", lat, NW * GA + 2);
        chk("p4_count", count_a, 25);
        chk("p4_overflow", overflow_a, 0);
        chk("p4_busy_done", busy_a, 1);
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!valid_a || count_a !== 8'd25 || gate_a) bad++;
        end
        chk("hold_stable", bad, 0);
        ack_a = 1'b1;
        @(negedge clk);
        ack_a = 1'b0;
        chk("ack_valid", valid_a, 0);
        chk("ack_busy", busy_a, 0);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy_a) bad++;
        end
        chk("no_queued_start", bad, 0);
        mode = 2;
        @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        lat = 0;
        for (int t = 1; t <= NW * GB + 50; t++) begin
            if (valid_b) begin
                lat = t;
                break;
            end
            @(negedge clk);
        end
        chk("sat_latency", lat, NW * GB + 2);
        chk("sat_count", count_b, 255);
        chk("sat_overflow", overflow_b, 1);
        ack_b = 1'b1;
        @(negedge clk);
        ack_b = 1'b0;
        run_a(0, ghi, lat);
        chk("p2_count", count_a, 50);
        chk("p2_overflow", overflow_a, 0);
        chk("p2_latency", lat, NW * GA + 2);
        ack_a = 1'b1;
        @(negedge clk);
        ack_a = 1'b0;
        mode = 1;
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (50) @(negedge clk);
        chk("mid_gate_pre", gate_a, 1);
        #5 reset = 1'b0;
        #1;
        chk("mid_rst_gate", gate_a, 0);
        chk("mid_rst_busy", busy_a, 0);
        chk("mid_rst_valid", valid_a, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        run_a(0, ghi, lat);
        chk("post_rst_count", count_a, 25);
        chk("post_rst_latency", lat, NW * GA + 2);
        chk("post_rst_gate_len", ghi, NW * GA);
        ack_a = 1'b1;
        @(negedge clk);
        ack_a = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
